fft_bf_pair_buf: RTL and testbench

//  Radix-2 DIF input pairing stage; sits directly upstream of the butterfly op.

---
 rtl/fft_bf_pair_buf_pkg.sv | 40 ++++
 rtl/fft_dly_ram.sv | 38 +++
 rtl/fft_bf_pair_buf.sv | 154 +++++++++++++++
 tb/tb_fft_bf_pair_buf.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_bf_pair_buf_pkg.sv
// -----------------------------------------------------------------------------
// fft_bf_pair_buf_pkg
//   Shared FFT definitions for the pairing stage and its delay RAM.
//   Provides the sample-format macros used across the FFT stages:
//     `CPLX_WIDTH            complex sample width, {real, imag}
//     `REAL_MSB/`REAL_LSB    real field bounds inside a complex word
//     `IMGN_MSB/`IMGN_LSB    imaginary field bounds inside a complex word
//     `FFT_HALF_LEN          default half-frame length for the stages
//   Also provides package-level mirrors of those values, the complex word
//   type, and the FILL/PAIR phase encoding.
//
//   Optional feature macro consumed by the top: FFT_PAIR_TWIDX_EN.
// -----------------------------------------------------------------------------
`ifndef FFT_INC_H
`define FFT_INC_H
`define CPLX_WIDTH   32
`define REAL_MSB     31
`define REAL_LSB     16
`define IMGN_MSB     15
`define IMGN_LSB     0
`define FFT_HALF_LEN 8
`endif

package fft_bf_pair_buf_pkg;

  localparam int CPLX_W   = `CPLX_WIDTH;
  localparam int REAL_MSB = `REAL_MSB;
  localparam int REAL_LSB = `REAL_LSB;
  localparam int IMGN_MSB = `IMGN_MSB;
  localparam int IMGN_LSB = `IMGN_LSB;

  typedef logic [CPLX_W-1:0] cplx_t;

  // The MSB of the frame counter selects the phase directly.
  typedef enum logic {
    PH_FILL = 1'b0,
    PH_PAIR = 1'b1
  } phase_e;

endpackage

// File: rtl/fft_dly_ram.sv
// -----------------------------------------------------------------------------
// fft_dly_ram
//   Half-frame delay memory: DEPTH x WIDTH, one synchronous write port and
//   one asynchronous (distributed) read port. Contents are not reset.
//
// Ports
//   clk      in   rising-edge clock for the write port
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   raddr_i  in   read address (combinational read)
//   rdata_o  out  read data
// -----------------------------------------------------------------------------
module fft_dly_ram
  import fft_bf_pair_buf_pkg::*;
#(
  parameter int DEPTH = `FFT_HALF_LEN,
  parameter int WIDTH = CPLX_W
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fft_bf_pair_buf.sv
// -----------------------------------------------------------------------------
// fft_bf_pair_buf
//   Radix-2 DIF input pairing stage feeding the butterfly. The first half of
//   each frame is written into a delay RAM; each sample of the second half is
//   paired with the stored sample HALF_LEN earlier and registered as the
//   ia/ib operand pair. Data passes through bit-exact.
//
// Parameters
//   HALF_LEN   pair distance, power of 2 in 2..1024
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   input sample valid
//   in_ready   out  stage accepts a sample this cycle
//   in_data    in   complex sample {real, imag}
//   out_valid  out  ia/ib pair valid
//   out_ready  in   downstream consumes the pair this cycle
//   out_ia     out  sample k of the frame
//   out_ib     out  sample k+HALF_LEN of the frame
//   out_last   out  final pair of the frame (k = HALF_LEN-1)
//   out_k      out  pair index k, only when FFT_PAIR_TWIDX_EN is defined
//
// Configuration macro: FFT_PAIR_TWIDX_EN adds the registered out_k port.
// -----------------------------------------------------------------------------
module fft_bf_pair_buf
  import fft_bf_pair_buf_pkg::*;
#(
  parameter int HALF_LEN = `FFT_HALF_LEN
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [`CPLX_WIDTH-1:0]      in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [`CPLX_WIDTH-1:0]      out_ia,
  output logic [`CPLX_WIDTH-1:0]      out_ib,
  output logic                        out_last
`ifdef FFT_PAIR_TWIDX_EN
  ,
  output logic [$clog2(HALF_LEN)-1:0] out_k
`endif
);

  localparam int CNT_W = $clog2(HALF_LEN) + 1;
  localparam int KW    = CNT_W - 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KW-1:0]    k;
  phase_e           phase;

  logic             out_valid_q, out_valid_d;
  logic             out_last_q,  out_last_d;
  cplx_t            out_ia_q,    out_ia_d;
  cplx_t            out_ib_q,    out_ib_d;
`ifdef FFT_PAIR_TWIDX_EN
  logic [KW-1:0]    out_k_q,     out_k_d;
`endif

  logic             in_xfer;
  logic             ram_we;
  logic             pair_load;
  cplx_t            ram_rdata;

  assign k     = cnt_q[KW-1:0];
  assign phase = phase_e'(cnt_q[CNT_W-1]);

  // FILL never backpressures; PAIR accepts only when the output register
  // is empty or being drained in the same cycle.
  assign in_ready  = (phase == PH_FILL) || !out_valid_q || out_ready;
  assign in_xfer   = in_valid && in_ready;
  assign ram_we    = in_xfer && (phase == PH_FILL);
  assign pair_load = in_xfer && (phase == PH_PAIR);

  // RAM address is k in both phases: written during FILL, read (async)
  // at pair creation during PAIR. FILL writes of the next frame can only
  // start after the last pair has already captured its RAM word.
  fft_dly_ram #(
    .DEPTH (HALF_LEN),
    .WIDTH (CPLX_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (k),
    .wdata_i (in_data),
    .raddr_i (k),
    .rdata_o (ram_rdata)
  );

  // 2*HALF_LEN is a power of two, so the counter wraps naturally.
  always_comb begin
    cnt_d = cnt_q;
    if (in_xfer) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_ia_d    = out_ia_q;
    out_ib_d    = out_ib_q;
`ifdef FFT_PAIR_TWIDX_EN
    out_k_d     = out_k_q;
`endif
    if (pair_load) begin
      out_valid_d = 1'b1;
      // HALF_LEN is a power of two, so k==HALF_LEN-1 is all-ones.
      out_last_d  = &k;
      out_ia_d    = ram_rdata;
      out_ib_d    = in_data;
`ifdef FFT_PAIR_TWIDX_EN
      out_k_d     = k;
`endif
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  // ---- stage boundary: counter and output pair register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_ia_q    <= '0;
      out_ib_q    <= '0;
`ifdef FFT_PAIR_TWIDX_EN
      out_k_q     <= '0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_ia_q    <= out_ia_d;
      out_ib_q    <= out_ib_d;
`ifdef FFT_PAIR_TWIDX_EN
      out_k_q     <= out_k_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_ia    = out_ia_q;
  assign out_ib    = out_ib_q;
`ifdef FFT_PAIR_TWIDX_EN
  assign out_k     = out_k_q;
`endif

endmodule

// File: tb/tb_fft_bf_pair_buf.sv
// -----------------------------------------------------------------------------
// tb_fft_bf_pair_buf
//   Directed and randomized bench for the DIF pairing stage, HALF_LEN=8.
//   A monitor keeps its own frame model and expected-pair queue.
// -----------------------------------------------------------------------------
module tb_fft_bf_pair_buf;

  localparam int HL = 8;
  localparam int KW = 3;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ia;
  logic [CW-1:0] out_ib;
  logic          out_last;
  logic [KW-1:0] out_k_obs;
`ifdef FFT_PAIR_TWIDX_EN
  logic [KW-1:0] out_k;
  assign out_k_obs = out_k;
`else
  assign out_k_obs = '0;
`endif

  logic rnd_mode = 1'b0;
  logic rnd_rdy  = 1'b1;
  logic rdy_man  = 1'b1;
  assign out_ready = rnd_mode ? rnd_rdy : rdy_man;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [CW-1:0] ia;
    logic [CW-1:0] ib;
    logic          last;
    logic [KW-1:0] k;
  } pair_t;

  pair_t         exp_q[$];
  logic [CW-1:0] m_buf [HL];
  int            m_cnt = 0;

  fft_bf_pair_buf #(.HALF_LEN(HL)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ia    (out_ia),
    .out_ib    (out_ib),
    .out_last  (out_last)
`ifdef FFT_PAIR_TWIDX_EN
    ,
    .out_k     (out_k)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample n: real = n, imag = -n (16-bit two's complement each).
  function automatic logic [CW-1:0] smp(input int n);
    logic [15:0] re, im;
    re = 16'(n);
    im = 16'(-n);
    return {re, im};
  endfunction

  task automatic send(input logic [CW-1:0] d);
    in_data  = d;
    in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    check("send_timeout", 1, 0);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(posedge clk);
    idle(2);
    check(tag, exp_q.size(), 0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    rnd_rdy = 1'($urandom_range(0, 1));
  end

  // Monitor / scoreboard, evaluated on the falling edge.
  initial begin : monitor
    logic          hold, pend;
    logic [CW-1:0] hold_ia, hold_ib, pend_ib;
    pair_t         p, e;
    hold = 1'b0;
    pend = 1'b0;
    hold_ia = '0;
    hold_ib = '0;
    pend_ib = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_cnt = 0;
        exp_q.delete();
        hold = 1'b0;
        pend = 1'b0;
      end else begin
        if (pend) begin
          check("latency_valid", out_valid, 1);
          check("latency_ib", out_ib, pend_ib);
          pend = 1'b0;
        end
        if (hold) begin
          check("hold_valid", out_valid, 1);
          check("hold_ia", out_ia, hold_ia);
          check("hold_ib", out_ib, hold_ib);
        end
        if (out_valid && out_ready) begin
          check("pair_queued", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("pair_ia", out_ia, e.ia);
            check("pair_ib", out_ib, e.ib);
            check("pair_last", out_last, e.last);
`ifdef FFT_PAIR_TWIDX_EN
            check("pair_k", out_k_obs, e.k);
`endif
          end
        end
        hold    = out_valid && !out_ready;
        hold_ia = out_ia;
        hold_ib = out_ib;
        if (in_valid && in_ready) begin
          if (m_cnt < HL) begin
            m_buf[m_cnt] = in_data;
          end else begin
            p.ia   = m_buf[m_cnt-HL];
            p.ib   = in_data;
            p.last = (m_cnt == 2*HL-1);
            p.k    = KW'(m_cnt - HL);
            exp_q.push_back(p);
            pend    = 1'b1;
            pend_ib = in_data;
          end
          m_cnt = (m_cnt + 1) % (2*HL);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got %0d checks expected completion", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int c0;
    // Reset state
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_ia", out_ia, 0);
    check("rst_out_ib", out_ib, 0);
    check("rst_out_k", out_k_obs, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    idle(1);

    // Test 1: one frame, out_ready high
    rdy_man = 1'b1;
    for (int n = 0; n < 16; n++) send(smp(n));
    drain("t1_drain");

    // Test 2: stall 3 cycles at pair 2
    for (int n = 0; n < 11; n++) send(smp(n));
    rdy_man  = 1'b0;
    in_data  = smp(11);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_stall_in_ready", in_ready, 0);
      check("t2_stall_ia", out_ia, smp(2));
      check("t2_stall_ib", out_ib, smp(10));
      @(posedge clk);
      #1;
    end
    rdy_man = 1'b1;
    for (int n = 11; n < 16; n++) send(smp(n));
    drain("t2_drain");

    // Test 3: two frames back-to-back, one sample per cycle
    c0 = cyc;
    for (int n = 0; n < 32; n++) send(smp(n));
    check("t3_throughput_cycles", cyc - c0, 32);
    drain("t3_drain");

    // Test 4: async reset at cnt=11 with a pair held
    for (int n = 0; n < 11; n++) send(smp(200 + n));
    rdy_man = 1'b0;
    @(negedge clk);
    check("t4_pre_rst_valid", out_valid, 1);
    check("t4_pre_rst_ib", out_ib, smp(210));
    #2;
    rst = 1'b1;
    #1;
    check("t4_rst_valid", out_valid, 0);
    check("t4_rst_last", out_last, 0);
    check("t4_rst_ib", out_ib, 0);
    check("t4_rst_in_ready", in_ready, 1);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    rdy_man = 1'b1;
    idle(1);
    for (int n = 0; n < 16; n++) send(smp(300 + n));
    drain("t4_drain");

    // Test 5: random valid gaps and random out_ready, 100 frames
    rnd_mode = 1'b1;
    for (int f = 0; f < 100; f++) begin
      for (int n = 0; n < 16; n++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        send($urandom);
      end
    end
    rnd_mode = 1'b0;
    drain("t5_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
